// File: rtl/sdfilter_train.sv
// sdfilter_train: pulse-train multiplicity filter.
// The discriminator input is synchronised and edge-detected. Pulses whose gaps
// fall inside the gate masks are grouped into trains. Each accepted pulse
// strobes its position in the train. When a train ends, one {mult, span} event
// is offered on a valid/ready port.
// Optional multiplicity histogram: define SDFILTER_TRAIN_HIST_EN.
`timescale 1ns/1ps
module sdfilter_train #(
    parameter int STAGES   = 16,
    parameter int WIN      = 16,
    parameter int CW       = 16,
    parameter int MIN_MULT = 2,
    parameter int MW       = $clog2(STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in,
    input  logic [WIN-1:0]            gate0,
    input  logic [WIN-1:0]            gaten,
    output logic [STAGES-1:0]         out,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [MW-1:0]             ev_mult,
    output logic [CW-1:0]             ev_span,
    output logic [CW-1:0]             drop_cnt,
    input  logic [$clog2(STAGES)-1:0] hist_addr,
    input  logic                      hist_clr,
    output logic [CW-1:0]             hist_data
);
    localparam int GW = $clog2(WIN + 1);
    localparam int AW = $clog2(STAGES);
    localparam logic [MW-1:0] MULT_MAX = MW'(STAGES);
    localparam logic [MW-1:0] MULT_MIN = MW'(MIN_MULT);
    localparam logic [GW-1:0] GAP_MAX  = GW'(WIN);
    localparam int unsigned   LAST     = STAGES - 1;

    typedef enum logic {S_IDLE, S_TRAIN} state_t;
    state_t state, state_nxt;

    logic [1:0]        sb;
    logic              p;
    logic [MW-1:0]     mult, mult_nxt;
    logic [GW-1:0]     gap, gap_nxt;
    logic [CW-1:0]     span, span_nxt, span_inc;
    logic [CW-1:0]     span_last, span_last_nxt;
    logic [WIN-1:0]    mask;
    logic              gap_ok, accept, train_end, offer;
    logic [STAGES-1:0] out_nxt;

    assign span_inc = (span == '1) ? span : span + CW'(1);

    // Two-flop synchroniser followed by a rising-edge detector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb <= '0;
            p  <= 1'b0;
        end else begin
            sb <= {sb[0], in};
            p  <= sb[0] & ~sb[1];
        end
    end

    // Gate check: is the current gap allowed for the next pulse of this train
    always_comb begin
        mask   = (mult == MW'(1)) ? gate0 : gaten;
        gap_ok = 1'b0;
        for (int unsigned i = 0; i < unsigned'(WIN); i++)
            if (mask[i] && gap == GW'(i + 1)) gap_ok = 1'b1;
        accept = (state == S_TRAIN) && p && gap_ok;
    end

    // Tracker state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: train start, accepted pulse, restart on a rejected pulse, timeout.
    // span_last freezes the span at the last accepted pulse, so the gap that ends
    // a train is not counted into the event.
    always_comb begin
        state_nxt     = state;
        mult_nxt      = mult;
        gap_nxt       = gap;
        span_nxt      = span;
        span_last_nxt = span_last;
        train_end     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (p) begin
                    state_nxt     = S_TRAIN;
                    mult_nxt      = MW'(1);
                    gap_nxt       = '0;
                    span_nxt      = '0;
                    span_last_nxt = '0;
                end
            end
            S_TRAIN: begin
                if (accept) begin
                    if (mult != MULT_MAX) mult_nxt = mult + MW'(1);
                    gap_nxt       = '0;
                    span_nxt      = span_inc;
                    span_last_nxt = span_inc;
                end else if (p) begin
                    train_end     = 1'b1;
                    mult_nxt      = MW'(1);
                    gap_nxt       = '0;
                    span_nxt      = '0;
                    span_last_nxt = '0;
                end else if (gap == GAP_MAX) begin
                    train_end = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt  = gap + GW'(1);
                    span_nxt = span_inc;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: position strobe for the current pulse and event offer on train end
    always_comb begin
        out_nxt    = '0;
        out_nxt[0] = p && !accept;
        for (int unsigned k = 1; k < LAST + 1; k++)
            out_nxt[k] = accept && ((k == LAST) ? (mult >= MW'(k)) : (mult == MW'(k)));
        offer = train_end && (mult >= MULT_MIN);
    end

    // Tracker datapath and strobe register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult      <= '0;
            gap       <= '0;
            span      <= '0;
            span_last <= '0;
            out       <= '0;
        end else begin
            mult      <= mult_nxt;
            gap       <= gap_nxt;
            span      <= span_nxt;
            span_last <= span_last_nxt;
            out       <= out_nxt;
        end
    end

    // Event holding register; an offer that cannot load is counted as a drop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ev_valid <= 1'b0;
            ev_mult  <= '0;
            ev_span  <= '0;
            drop_cnt <= '0;
        end else if (offer && (!ev_valid || ev_ready)) begin
            ev_valid <= 1'b1;
            ev_mult  <= mult;
            ev_span  <= span_last;
        end else begin
            if (ev_valid && ev_ready) ev_valid <= 1'b0;
            if (offer && drop_cnt != '1) drop_cnt <= drop_cnt + CW'(1);
        end
    end

`ifdef SDFILTER_TRAIN_HIST_EN
    logic [CW-1:0] bins [STAGES];
    logic [AW-1:0] bin_sel;

    assign bin_sel = AW'(mult - MW'(1));

    // Histogram bins, clear beats increment; registered read port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < LAST + 1; i++) bins[i] <= '0;
            hist_data <= '0;
        end else begin
            if (hist_clr) begin
                for (int unsigned i = 0; i < LAST + 1; i++) bins[i] <= '0;
            end else if (train_end && bins[bin_sel] != '1) begin
                bins[bin_sel] <= bins[bin_sel] + CW'(1);
            end
            hist_data <= bins[hist_addr];
        end
    end
`else
    logic hist_unused;
    assign hist_unused = ^{hist_addr, hist_clr};
    assign hist_data   = '0;
`endif

endmodule

// File: tb/tb_sdfilter_train.sv
// Self-checking bench for sdfilter_train (STAGES=4, WIN=8, MIN_MULT=2).
`timescale 1ns/1ps
module tb_sdfilter_train;
    localparam int STAGES   = 4;
    localparam int WIN      = 8;
    localparam int CW       = 16;
    localparam int MIN_MULT = 2;
    localparam int MW       = $clog2(STAGES + 1);
`ifdef SDFILTER_TRAIN_HIST_EN
    localparam int HIST_B0 = 1;
`else
    localparam int HIST_B0 = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              din = 1'b0;
    logic              ev_ready = 1'b1;
    logic              hist_clr = 1'b0;
    logic [1:0]        hist_addr = '0;
    logic [WIN-1:0]    gate0 = '1;
    logic [WIN-1:0]    gaten = '1;
    logic [STAGES-1:0] out;
    logic              ev_valid;
    logic [MW-1:0]     ev_mult;
    logic [CW-1:0]     ev_span, drop_cnt, hist_data;

    sdfilter_train #(.STAGES(STAGES), .WIN(WIN), .CW(CW), .MIN_MULT(MIN_MULT)) dut (
        .clk(clk), .reset(reset), .in(din), .gate0(gate0), .gaten(gaten),
        .out(out), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_mult(ev_mult),
        .ev_span(ev_span), .drop_cnt(drop_cnt), .hist_addr(hist_addr),
        .hist_clr(hist_clr), .hist_data(hist_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [MW-1:0] m;
        logic [CW-1:0] s;
    } ev_t;

    int  sq[$];
    ev_t eq[$];

    typedef struct {
        int         np;
        int         sp;
        int         sp_last;
        logic [7:0] g0;
        logic [7:0] gn;
        int         strb;
        int         has_ev;
        int         em;
        int         es;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_then(input int spacing);
        din = 1'b1;
        tick(1);
        din = 1'b0;
        if (spacing > 1) tick(spacing - 1);
    endtask

    // Scoreboard: strobes and accepted events are popped as the DUT produces them
    always @(negedge clk) begin : mon
        int  k;
        ev_t e;
        if (reset) begin
            if (out != '0) begin
                if (sq.size() == 0) check("unexpected_strobe", 32'(out), 32'd0);
                else begin
                    k = sq.pop_front();
                    check("strobe", 32'(out), 32'd1 << k);
                end
            end
            if (ev_valid && ev_ready) begin
                if (eq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_event: got mult %0d span %0d, want none", ev_mult, ev_span);
                end else begin
                    e = eq.pop_front();
                    check("ev_mult", 32'(ev_mult), 32'(e.m));
                    check("ev_span", 32'(ev_span), 32'(e.s));
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tv[8];
        // strb packs the expected strobe index of pulse i in bits [2i+1:2i]
        tv[0] = '{np:3, sp:4,  sp_last:4,  g0:8'hFF, gn:8'hFF, strb:'h24,  has_ev:1, em:3, es:8};
        tv[1] = '{np:1, sp:1,  sp_last:1,  g0:8'hFF, gn:8'hFF, strb:'h0,   has_ev:0, em:0, es:0};
        tv[2] = '{np:3, sp:4,  sp_last:6,  g0:8'hFF, gn:8'h0F, strb:'h4,   has_ev:1, em:2, es:4};
        tv[3] = '{np:6, sp:2,  sp_last:2,  g0:8'hFF, gn:8'hFF, strb:'hFE4, has_ev:1, em:4, es:10};
        tv[4] = '{np:2, sp:9,  sp_last:9,  g0:8'hFF, gn:8'hFF, strb:'h4,   has_ev:1, em:2, es:9};
        tv[5] = '{np:2, sp:10, sp_last:10, g0:8'hFF, gn:8'hFF, strb:'h0,   has_ev:0, em:0, es:0};
        tv[6] = '{np:3, sp:5,  sp_last:5,  g0:8'h08, gn:8'hFF, strb:'h24,  has_ev:1, em:3, es:10};
        tv[7] = '{np:2, sp:4,  sp_last:4,  g0:8'h08, gn:8'hFF, strb:'h0,   has_ev:0, em:0, es:0};

        // Reset state
        tick(3);
        check("rst_out", 32'(out), 32'd0);
        check("rst_ev_valid", 32'(ev_valid), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_hist_data", 32'(hist_data), 32'd0);
        reset = 1'b1;
        tick(2);

        // Strobe and event latency for a 3-pulse train, 4 cycles apart
        sq.push_back(0); sq.push_back(1); sq.push_back(2);
        eq.push_back('{m: MW'(3), s: CW'(8)});
        pulse_then(4);
        pulse_then(4);
        din = 1'b1; tick(1); din = 1'b0; tick(1);
        check("lat_out_early", 32'(out), 32'd0);
        tick(1);
        check("lat_out2", 32'(out), 32'h4);
        tick(8);
        check("lat_ev_early", 32'(ev_valid), 32'd0);
        tick(1);
        check("lat_ev_valid", 32'(ev_valid), 32'd1);
        tick(3);
        check("lat_ev_cleared", 32'(ev_valid), 32'd0);

        // Table of trains
        for (int v = 0; v < 8; v++) begin
            gate0 = tv[v].g0;
            gaten = tv[v].gn;
            for (int i = 0; i < tv[v].np; i++) sq.push_back((tv[v].strb >> (2 * i)) & 3);
            if (tv[v].has_ev != 0) eq.push_back('{m: MW'(tv[v].em), s: CW'(tv[v].es)});
            for (int i = 0; i < tv[v].np; i++) begin
                if (i == tv[v].np - 1)      pulse_then(1);
                else if (i == tv[v].np - 2) pulse_then(tv[v].sp_last);
                else                        pulse_then(tv[v].sp);
            end
            tick(WIN + 8);
            check("strobes_pending", 32'(sq.size()), 32'd0);
            check("events_pending", 32'(eq.size()), 32'd0);
        end
        gate0 = '1;
        gaten = '1;

        // Histogram: clear, one single-pulse train, read bins 0 and 1
        hist_clr = 1'b1; tick(1); hist_clr = 1'b0;
        sq.push_back(0);
        pulse_then(1);
        tick(WIN + 8);
        hist_addr = 2'd0; tick(1);
        check("hist_bin0", 32'(hist_data), 32'(HIST_B0));
        hist_addr = 2'd1; tick(1);
        check("hist_bin1", 32'(hist_data), 32'd0);

        // Backpressure: first event held stable, second dropped
        ev_ready = 1'b0;
        sq.push_back(0); sq.push_back(1);
        eq.push_back('{m: MW'(2), s: CW'(3)});
        pulse_then(3); pulse_then(1);
        tick(WIN + 6);
        sq.push_back(0); sq.push_back(1); sq.push_back(2);
        pulse_then(2); pulse_then(2); pulse_then(1);
        tick(WIN + 6);
        check("bp_ev_valid", 32'(ev_valid), 32'd1);
        check("bp_ev_mult", 32'(ev_mult), 32'd2);
        check("bp_ev_span", 32'(ev_span), 32'd3);
        check("bp_drop_cnt", 32'(drop_cnt), 32'd1);
        ev_ready = 1'b1;
        tick(1);
        check("bp_ev_cleared", 32'(ev_valid), 32'd0);
        check("bp_events_pending", 32'(eq.size()), 32'd0);

        // Reset mid-train with an event held and a nonzero drop count
        ev_ready = 1'b0;
        sq.push_back(0); sq.push_back(1);
        eq.push_back('{m: MW'(2), s: CW'(3)});
        pulse_then(3); pulse_then(1);
        tick(WIN + 6);
        sq.push_back(0);
        pulse_then(3);
        din = 1'b1; tick(1); din = 1'b0; tick(2);
        check("mid_out1", 32'(out), 32'h2);
        reset = 1'b0;
        #1;
        check("mid_rst_out", 32'(out), 32'd0);
        check("mid_rst_ev_valid", 32'(ev_valid), 32'd0);
        check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        eq.delete();
        tick(3);
        reset = 1'b1;
        ev_ready = 1'b1;
        tick(WIN + 8);
        check("post_rst_ev_valid", 32'(ev_valid), 32'd0);
        check("post_rst_strobes", 32'(sq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sdfilter_train.md
# sdfilter_train

Parametrised pulse-train multiplicity filter for the neutron front-end. It sits between a raw discriminator input and the event readout logic. It edge-detects the input and tracks trains of pulses whose inter-pulse gaps fall inside programmable gate masks. It flags each pulse with its position in the train, and on train end emits one `{multiplicity, span}` event through a valid/ready port. Optionally it accumulates a multiplicity histogram.

## Interface
- `STAGES`, 16: multiplicity stages, 2..32; width of `out`; multiplicity saturates here.
- `WIN`, 16: gate window length in cycles, 1..32; width of gate masks.
- `CW`, 16: width of span, drop and histogram counters.
- `MIN_MULT`, 2: minimum multiplicity for a train to produce an event, 1..`STAGES`.
- `MW`, `$clog2(STAGES+1)`: derived multiplicity width; do not override.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-low reset.
- `in` in 1: asynchronous discriminator input.
- `gate0` in `WIN`: allowed gaps (bit i = gap of i+1 cycles) between pulse 1 and pulse 2.
- `gaten` in `WIN`: allowed gaps for every later pulse pair.
- `out` out `STAGES`: one-cycle strobe; bit k = accepted pulse was (k+1)th of train.
- `ev_valid` out 1: event held.
- `ev_ready` in 1: consumer accepts.
- `ev_mult` out `MW`: train multiplicity, saturated at `STAGES`.
- `ev_span` out `CW`: cycles from first to last pulse, saturating.
- `drop_cnt` out `CW`: events lost to backpressure, saturating.
- `hist_addr` in `$clog2(STAGES)`: histogram bin select.
- `hist_clr` in 1: synchronous clear of all bins.
- `hist_data` out `CW`: selected bin count.

## Operation
- Sync/edge: two-flop synchroniser `sb[1:0]`. Register `p <= sb[0] & !sb[1]`; `p` is the internal pulse, 1 cycle wide.
- Tracker state: `active`, `mult` (MW, sat `STAGES`), `gap` (0..`WIN`), `span` (CW, sat).
- While `active` and no `p`: `gap++`, `span++` (both saturating).
- Qualifying pulse: `p & active & mask[gap-1]`, with `gap` in 1..`WIN`. `mask` is `gate0` when `mult==1`, else `gaten`.
  - Effect: `mult++` (sat), `gap<=0`. `span` counts this cycle normally.
  - Strobe: `out[min(mult,STAGES-1)]`.
- Non-qualifying `p` while `active`: current train ends. The same pulse starts a new train: `mult<=1`, `gap<=0`, `span<=0`, `out[0]` strobes.
- `p` while idle: start train as above, `out[0]`.
- Timeout: `active`, no `p`, `gap==WIN` → train ends, `active<=0`.
- Train end: if `mult>=MIN_MULT`, offer event `{mult, span}`.
  - Output register empty, or `ev_ready` high this cycle: load register, `ev_valid<=1`.
  - Otherwise: discard, `drop_cnt++` (sat).
- Handshake: `ev_valid` and data stay stable until `ev_valid & ev_ready`. On acceptance, `ev_valid` clears unless a new event loads in the same cycle.
- Reset, asynchronous: every register clears at once, including mid-train. All outputs are 0 while `reset` is low. A train in progress is discarded and produces no event. `drop_cnt` clears.

## Timing
- `in` rises before edge t → `sb[0]`=1 after t → `p`=1 after t+1 → `out` strobe after t+2, one cycle wide.
- Event latency: `ev_valid` rises at the edge after the train-end cycle.
  - Timeout case: `WIN+2` cycles after the last `p`.
- Throughput: one event per cycle while `ev_ready` stays high.
- `hist_data`: registered, 1-cycle latency from `hist_addr`.

## Configuration
- `SDFILTER_TRAIN_HIST_EN` defined:
  - Bins: `STAGES` counters, `CW` wide, saturating. Every completed train increments bin `mult-1`, regardless of `MIN_MULT` or drop.
  - Clear: `hist_clr` zeroes all bins next edge; clear wins over a simultaneous increment. Bins reset to 0.
- Undefined: no counters. `hist_addr` and `hist_clr` are ignored; `hist_data` is tied to 0. Ports are always present.

## Test plan
Defaults: `STAGES=4`, `WIN=8`, `gate0=gaten=8'hFF`, `MIN_MULT=2`, `ev_ready=1` unless stated.
- 3 rising edges 4 cycles apart → `out[0]`, `out[1]`, `out[2]` strobe once each. `ev_valid` rises 10 cycles after the third `p`, with `ev_mult=3`, `ev_span=8`.
- Single edge → `out[0]` only, no event. With HIST_EN: bin0=1, read 1 cycle after `hist_addr=0`.
- `gaten=8'h0F`, gaps 4 then 6 → first train ends at the third pulse: event `mult=2`, `span=4`. The third pulse gives `out[0]` and starts a new train, which times out with no event.
- 6 edges 2 cycles apart → strobes `out[0..3]`, then `out[3]` twice more. Event `mult=4` (saturated), `span=10`.
- `ev_ready=0`, two qualifying trains → first event held stable, second dropped, `drop_cnt=1`. Raising `ev_ready` clears `ev_valid` after one cycle.
- `reset` low mid-train (`mult=2`) → `out`, `ev_valid` and `drop_cnt` are 0 immediately. After release, no event appears.
